// File: rtl/fp_mul_arb_pkg.sv
// Shared types and constants for the floating-point multiplier arbiter.
package fp_mul_arb_pkg;

    localparam int unsigned FP_W_DEFAULT = 32;
    localparam int unsigned N_REQ_MAX    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_Z = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage : fp_mul_arb_pkg

// File: rtl/fp_mul_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((32'(ptr) + 32'(k)) % N_REQ);
            if (req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/fp_mul_arbiter.sv
// Shares one non-pipelined FP multiplier among N_REQ requesters, one op in flight.
// Optional build macro FP_MUL_ARB_STATS_EN adds op_count / busy_cycles counters.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned FP_W  = FP_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ*FP_W-1:0] req_a,
    input  logic [N_REQ*FP_W-1:0] req_b,
    input  logic [N_REQ-1:0]      req_stb,
    output logic [N_REQ-1:0]      req_ack,
    output logic [FP_W-1:0]       rsp_z,
    output logic [N_REQ-1:0]      rsp_stb,
    input  logic [N_REQ-1:0]      rsp_ack,
    output logic [FP_W-1:0]       mul_a,
    output logic                  mul_a_stb,
    input  logic                  mul_a_ack,
    output logic [FP_W-1:0]       mul_b,
    output logic                  mul_b_stb,
    input  logic                  mul_b_ack,
    input  logic [FP_W-1:0]       mul_z,
    input  logic                  mul_z_stb,
    output logic                  mul_z_ack
`ifdef FP_MUL_ARB_STATS_EN
    ,
    output logic [31:0]           op_count,
    output logic [31:0]           busy_cycles
`endif
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [FP_W-1:0]  op_a_q, op_a_d;
    logic [FP_W-1:0]  op_b_q, op_b_d;
    logic [FP_W-1:0]  res_q, res_d;
    logic             a_done_q, a_done_d;
    logic             b_done_q, b_done_d;
    logic             a_now, b_now;
    logic             resp_done;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_vld;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req       (req_stb),
        .ptr       (ptr_q),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign mul_a = op_a_q;
    assign mul_b = op_b_q;
    assign rsp_z = res_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
        end
    end

    // Next-state, handshake strobes and datapath updates.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_d     = res_q;
        a_done_d  = a_done_q;
        b_done_d  = b_done_q;
        a_now     = 1'b0;
        b_now     = 1'b0;
        resp_done = 1'b0;
        req_ack   = '0;
        rsp_stb   = '0;
        mul_a_stb = 1'b0;
        mul_b_stb = 1'b0;
        mul_z_ack = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ack[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    op_a_d  = req_a[32'(grant_idx) * FP_W +: FP_W];
                    op_b_d  = req_b[32'(grant_idx) * FP_W +: FP_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A and B complete independently; leave once both are in.
                mul_a_stb = !a_done_q;
                mul_b_stb = !b_done_q;
                a_now = a_done_q | mul_a_ack;
                b_now = b_done_q | mul_b_ack;
                if (a_now && b_now) begin
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    state_d  = WAIT_Z;
                end else begin
                    a_done_d = a_now;
                    b_done_d = b_now;
                end
            end
            WAIT_Z: begin
                mul_z_ack = 1'b1;
                if (mul_z_stb) begin
                    res_d   = mul_z;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_stb[owner_q] = 1'b1;
                if (rsp_ack[owner_q]) begin
                    resp_done = 1'b1;
                    ptr_d     = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FP_MUL_ARB_STATS_EN
    // Completed-operation and non-idle cycle counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count    <= '0;
            busy_cycles <= '0;
        end else begin
            if (resp_done) begin
                op_count <= op_count + 32'd1;
            end
            if (state_q != IDLE) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
        end
    end
`endif

endmodule : fp_mul_arbiter

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural multiplier on the far side.
module tb_fp_mul_arbiter;
    import fp_mul_arb_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_stb, req_ack, rsp_stb, rsp_ack;
    logic [W-1:0]     rsp_z, mul_a, mul_b, mul_z;
    logic             mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack;
    logic             mul_z_stb, mul_z_ack;
`ifdef FP_MUL_ARB_STATS_EN
    logic [31:0]      op_count, busy_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;
    int a_dly = 0, b_dly = 0, z_lat = 0;
    int a_xfers = 0;
    int illegal_acks = 0;
    int bench_busy = 0;

    fp_mul_arbiter #(.N_REQ(N), .FP_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_stb   (req_stb),
        .req_ack   (req_ack),
        .rsp_z     (rsp_z),
        .rsp_stb   (rsp_stb),
        .rsp_ack   (rsp_ack),
        .mul_a     (mul_a),
        .mul_a_stb (mul_a_stb),
        .mul_a_ack (mul_a_ack),
        .mul_b     (mul_b),
        .mul_b_stb (mul_b_stb),
        .mul_b_ack (mul_b_ack),
        .mul_z     (mul_z),
        .mul_z_stb (mul_z_stb),
        .mul_z_ack (mul_z_ack)
`ifdef FP_MUL_ARB_STATS_EN
        ,
        .op_count    (op_count),
        .busy_cycles (busy_cycles)
`endif
    );

    initial forever #5 clk = ~clk;

    // Truncating single-precision multiply for normal operands (exact for test values).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] m;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) return {s, 8'(e + 1), m[46:24]};
        return {s, 8'(e), m[45:23]};
    endfunction

    // Behavioural multiplier: configurable ack delays and result latency.
    initial begin
        bit          have_a, have_b, comp, pa, pb, pz;
        int          aw, bw, lc;
        logic [31:0] av, bv;
        have_a = 0; have_b = 0; comp = 0; pa = 0; pb = 0; pz = 0;
        aw = 0; bw = 0; lc = 0; av = '0; bv = '0;
        mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0; mul_z = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_a = 0; have_b = 0; comp = 0; pa = 0; pb = 0; pz = 0; aw = 0; bw = 0;
                mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0;
                continue;
            end
            if (pa) begin have_a = 1; a_xfers++; end
            if (pb) have_b = 1;
            if (pz) begin
                mul_z_stb = 1'b0; comp = 0; have_a = 0; have_b = 0; aw = 0; bw = 0;
            end
            if (have_a && have_b && !comp) begin comp = 1; lc = z_lat; end
            if (comp && !mul_z_stb) begin
                if (lc == 0) begin mul_z_stb = 1'b1; mul_z = fmul(av, bv); end
                else lc--;
            end
            if (mul_a_stb && !have_a) begin mul_a_ack = (aw >= a_dly); aw++; end
            else mul_a_ack = 1'b0;
            if (mul_b_stb && !have_b) begin mul_b_ack = (bw >= b_dly); bw++; end
            else mul_b_ack = 1'b0;
            pa = mul_a_stb && mul_a_ack;
            pb = mul_b_stb && mul_b_ack;
            if (pa) av = mul_a;
            if (pb) bv = mul_b;
            pz = mul_z_stb && mul_z_ack;
        end
    end

    // Observers: grants outside IDLE and non-IDLE cycle count.
    initial forever begin
        @(negedge clk);
        if (!rst_n) bench_busy = 0;
        else begin
            if (dut.state_q != IDLE) bench_busy++;
            if (dut.state_q != IDLE && req_ack != '0) illegal_acks++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    // Drives one grant/response exchange and reports what was observed.
    task automatic serve_one(input bit drop, output int gidx, output logic [31:0] z,
                             output int lat, output int wt, output bit ok);
        int c;
        ok = 1'b0; gidx = -1; z = '0; lat = 0; wt = 0;
        #1;
        c = 0;
        while (req_ack == '0 && c < 40) begin @(negedge clk); #1; c++; end
        wt = c;
        if (req_ack == '0) return;
        for (int i = 0; i < N; i++) if (req_ack[i]) gidx = i;
        @(negedge clk); #1;
        if (drop) req_stb[gidx] = 1'b0;
        c = 0;
        while (rsp_stb == '0 && c < 60) begin @(negedge clk); #1; c++; end
        lat = c;
        if (rsp_stb == '0) return;
        z = rsp_z;
        rsp_ack[gidx] = 1'b1;
        @(negedge clk); #1;
        rsp_ack[gidx] = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_stb = '0; rsp_ack = '0; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk); #1;
        vectors++; if ({req_ack, rsp_stb, mul_a_stb, mul_b_stb, mul_z_ack} !== '0) begin miscompares++; $display("FAIL reset_ctrl: got %h want 0", {req_ack, rsp_stb, mul_a_stb, mul_b_stb, mul_z_ack}); end
        vectors++; if ({rsp_z, mul_a, mul_b} !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {rsp_z, mul_a, mul_b}); end
        vectors++; if (dut.state_q !== IDLE || dut.ptr_q !== 2'd0) begin miscompares++; $display("FAIL reset_state: got state %0d ptr %0d want 0 0", dut.state_q, dut.ptr_q); end
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_single();
        int g, lat, wt; logic [31:0] z; bit ok;
        z_lat = 2;
        set_op(0, 32'h40A00000, 32'h40400000);
        req_stb[0] = 1'b1;
        serve_one(1'b1, g, z, lat, wt, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_timeout: got %0d want 1", ok); end
        vectors++; if (g !== 0) begin miscompares++; $display("FAIL single_grant: got %0d want 0", g); end
        vectors++; if (z !== 32'h41700000) begin miscompares++; $display("FAIL single_z: got %h want 41700000", z); end
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL single_latency: got %0d want 4", lat); end
        vectors++; if (dut.state_q !== IDLE || dut.ptr_q !== 2'd1) begin miscompares++; $display("FAIL single_after: got state %0d ptr %0d want 0 1", dut.state_q, dut.ptr_q); end
        z_lat = 0;
    endtask

    task automatic test_two_simultaneous();
        int g, lat, wt; logic [31:0] z; bit ok;
        set_op(1, 32'hC0A00000, 32'h40E00000);
        set_op(2, 32'h40A00000, 32'h40400000);
        req_stb[1] = 1'b1; req_stb[2] = 1'b1;
        serve_one(1'b1, g, z, lat, wt, ok);
        vectors++; if (!ok || g !== 1 || z !== 32'hC20C0000) begin miscompares++; $display("FAIL two_first: got ok %0d idx %0d z %h want 1 1 c20c0000", ok, g, z); end
        serve_one(1'b1, g, z, lat, wt, ok);
        vectors++; if (!ok || g !== 2 || z !== 32'h41700000) begin miscompares++; $display("FAIL two_second: got ok %0d idx %0d z %h want 1 2 41700000", ok, g, z); end
        vectors++; if (wt !== 0) begin miscompares++; $display("FAIL two_back_to_back: got wait %0d want 0", wt); end
    endtask

    task automatic test_all_continuous();
        logic [31:0] bv [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        logic [31:0] zv [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
        int g, lat, wt, ill0; logic [31:0] z; bit ok;
        apply_reset();
        ill0 = illegal_acks;
        for (int i = 0; i < N; i++) set_op(i, 32'h40000000, bv[i]);
        req_stb = '1;
        for (int k = 0; k < 8; k++) begin
            serve_one(1'b0, g, z, lat, wt, ok);
            vectors++; if (!ok || g !== k % 4 || z !== zv[k % 4]) begin miscompares++; $display("FAIL rr_op%0d: got ok %0d idx %0d z %h want 1 %0d %h", k, ok, g, z, k % 4, zv[k % 4]); end
            if (k > 0) begin
                vectors++; if (wt !== 0) begin miscompares++; $display("FAIL rr_b2b%0d: got wait %0d want 0", k, wt); end
            end
        end
        req_stb = '0;
        @(negedge clk); #1;
        vectors++; if (illegal_acks - ill0 !== 0) begin miscompares++; $display("FAIL rr_ack_outside_idle: got %0d want 0", illegal_acks - ill0); end
    endtask

    task automatic test_split_handshake();
        int a0, c;
        a_dly = 0; b_dly = 3; a0 = a_xfers;
        set_op(0, 32'h40A00000, 32'h40400000);
        req_stb[0] = 1'b1;
        #1;
        vectors++; if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL split_grant: got %b want 0001", req_ack); end
        @(negedge clk); #1;
        req_stb[0] = 1'b0;
        vectors++; if ({mul_a_stb, mul_b_stb} !== 2'b11) begin miscompares++; $display("FAIL split_e0: got %b want 11", {mul_a_stb, mul_b_stb}); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            vectors++; if (mul_a_stb !== 1'b0 || mul_b_stb !== (k < 4)) begin miscompares++; $display("FAIL split_stb%0d: got a %b b %b want 0 %b", k, mul_a_stb, mul_b_stb, k < 4); end
            vectors++; if (dut.state_q !== ((k < 4) ? ISSUE : WAIT_Z)) begin miscompares++; $display("FAIL split_state%0d: got %0d", k, dut.state_q); end
            if (k == 1) begin
                vectors++; if (mul_z_ack !== 1'b0) begin miscompares++; $display("FAIL split_zack_issue: got %b want 0", mul_z_ack); end
            end
        end
        c = 0;
        while (rsp_stb == '0 && c < 40) begin @(negedge clk); #1; c++; end
        vectors++; if (rsp_stb !== 4'b0001 || rsp_z !== 32'h41700000) begin miscompares++; $display("FAIL split_rsp: got stb %b z %h want 0001 41700000", rsp_stb, rsp_z); end
        vectors++; if (a_xfers - a0 !== 1) begin miscompares++; $display("FAIL split_a_once: got %0d want 1", a_xfers - a0); end
        rsp_ack[0] = 1'b1;
        @(negedge clk); #1;
        rsp_ack[0] = 1'b0;
        b_dly = 0;
    endtask

    task automatic test_slow_and_reset();
        int c;
        set_op(0, 32'hC0A00000, 32'h40E00000);
        set_op(1, 32'h40A00000, 32'h40400000);
        req_stb[0] = 1'b1;
        #1;
        c = 0;
        while (req_ack == '0 && c < 20) begin @(negedge clk); #1; c++; end
        vectors++; if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL slow_grant: got %b want 0001", req_ack); end
        @(negedge clk); #1;
        req_stb[1] = 1'b1;
        c = 0;
        while (rsp_stb == '0 && c < 40) begin @(negedge clk); #1; c++; end
        rsp_ack[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            vectors++; if (rsp_stb !== 4'b0001 || rsp_z !== 32'hC20C0000 || req_ack !== '0) begin miscompares++; $display("FAIL slow_hold%0d: got stb %b z %h ack %b want 0001 c20c0000 0000", k, rsp_stb, rsp_z, req_ack); end
            @(negedge clk); #1;
        end
        rsp_ack = 4'b0001;
        @(negedge clk); #1;
        rsp_ack = '0; req_stb[0] = 1'b0;
        #1;
        vectors++; if (req_ack !== 4'b0010) begin miscompares++; $display("FAIL slow_next_grant: got %b want 0010", req_ack); end
        @(negedge clk); #1;
        req_stb[1] = 1'b0;
        vectors++; if (dut.state_q !== ISSUE) begin miscompares++; $display("FAIL reset_pre_issue: got %0d want %0d", dut.state_q, ISSUE); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({req_ack, rsp_stb, mul_a_stb, mul_b_stb, mul_z_ack} !== '0 || {rsp_z, mul_a, mul_b} !== '0) begin miscompares++; $display("FAIL midop_reset_out: got %h %h want 0", {req_ack, rsp_stb, mul_a_stb, mul_b_stb, mul_z_ack}, {rsp_z, mul_a, mul_b}); end
        vectors++; if (dut.state_q !== IDLE || dut.ptr_q !== 2'd0) begin miscompares++; $display("FAIL midop_reset_state: got %0d %0d want 0 0", dut.state_q, dut.ptr_q); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); #1; if (rsp_stb != '0) c++; end
        vectors++; if (c !== 0 || dut.state_q !== IDLE) begin miscompares++; $display("FAIL dropped_no_rsp: got %0d rsp cycles state %0d want 0 0", c, dut.state_q); end
    endtask

`ifdef FP_MUL_ARB_STATS_EN
    task automatic test_stats();
        int g, lat, wt; logic [31:0] z; bit ok;
        apply_reset();
        z_lat = 1;
        for (int i = 0; i < 3; i++) begin
            set_op(i, 32'h40000000, 32'h40000000);
            req_stb[i] = 1'b1;
            serve_one(1'b1, g, z, lat, wt, ok);
        end
        repeat (3) @(negedge clk); #1;
        vectors++; if (op_count !== 32'd3) begin miscompares++; $display("FAIL stats_op_count: got %0d want 3", op_count); end
        vectors++; if (busy_cycles !== 32'(bench_busy)) begin miscompares++; $display("FAIL stats_busy: got %0d want %0d", busy_cycles, bench_busy); end
        z_lat = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_two_simultaneous();
        test_all_continuous();
        test_split_handshake();
        test_slow_and_reset();
`ifdef FP_MUL_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fp_mul_arbiter
